// File: rtl/window_3x3_builder.sv
// window_3x3_builder
// Buffers two image lines of a raster-order pixel stream and emits, once per
// centre pixel, the packed 3x3 neighbourhood with edge replication (clamping).
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous active-high reset, clears all state
//   frame_start   marks the first pixel of a frame (qualified by accept)
//   pixel_in      input pixel (RGB444 by default)
//   pixel_valid   pixel_in valid this cycle
//   in_ready      pixel is accepted this cycle when high (low during flush)
//   color_data    packed window: C,L,R,U,D,UL,UR,DL,DR from MSB to LSB
//   window_valid  one-cycle strobe per emitted centre
//   x_out, y_out  centre coordinates of color_data
module window_3x3_builder #(
    parameter int unsigned IMG_WIDTH  = 160,
    parameter int unsigned IMG_HEIGHT = 120,
    parameter int unsigned PIX_W      = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_start,
    input  logic [PIX_W-1:0]     pixel_in,
    input  logic                 pixel_valid,
    output logic                 in_ready,
    output logic [9*PIX_W-1:0]   color_data,
    output logic                 window_valid,
    output logic [15:0]          x_out,
    output logic [15:0]          y_out
);

    localparam int unsigned CW    = 16;
    localparam int unsigned IW    = 32;
    localparam int unsigned PTR_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

    localparam logic [IW-1:0]    LAST_IDX   = IW'(IMG_WIDTH * IMG_HEIGHT - 1);
    localparam logic [IW-1:0]    FIRST_EMIT = IW'(IMG_WIDTH + 1);
    localparam logic [CW-1:0]    X_LAST     = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0]    Y_LAST     = CW'(IMG_HEIGHT - 1);
    localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(IMG_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_RUN   = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    // index of the next pixel to be accepted in the current frame
    logic [IW-1:0]    in_idx;
    // coordinates of the next centre to be emitted
    logic [CW-1:0]    cen_x;
    logic [CW-1:0]    cen_y;
    logic [PTR_W-1:0] wr_ptr;

    // line_mid delays the stream by one line, line_top by two lines
    logic [PIX_W-1:0] line_mid [IMG_WIDTH];
    logic [PIX_W-1:0] line_top [IMG_WIDTH];

    // two most recent window columns (top, mid, bottom rows)
    logic [PIX_W-1:0] col_a_top, col_a_mid, col_a_bot;
    logic [PIX_W-1:0] col_b_top, col_b_mid, col_b_bot;

    logic             accept_c;
    logic             store_c;
    logic             restart_c;
    logic             emit_c;
    logic             shift_c;
    logic [PIX_W-1:0] shift_pix_c;
    logic [PIX_W-1:0] top_rd_c;
    logic [PIX_W-1:0] mid_rd_c;
    logic [PIX_W-1:0] win_c [3][3];
    logic [1:0]       r_up_c, r_dn_c, c_lf_c, c_rt_c;
    logic [9*PIX_W-1:0] pack_c;

    assign accept_c = pixel_valid & in_ready;

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state and control decode
    always_comb begin
        state_next  = state;
        store_c     = 1'b0;
        restart_c   = 1'b0;
        emit_c      = 1'b0;
        shift_c     = 1'b0;
        shift_pix_c = pixel_in;
        case (state)
            S_IDLE: begin
                if (accept_c && frame_start) begin
                    store_c    = 1'b1;
                    restart_c  = 1'b1;
                    state_next = S_FILL;
                end
            end
            S_FILL: begin
                if (accept_c) begin
                    store_c = 1'b1;
                    if (frame_start) begin
                        restart_c = 1'b1;
                    end else if (in_idx == FIRST_EMIT) begin
                        emit_c     = 1'b1;
                        state_next = (in_idx == LAST_IDX) ? S_FLUSH : S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (accept_c) begin
                    store_c = 1'b1;
                    if (frame_start) begin
                        restart_c  = 1'b1;
                        state_next = S_FILL;
                    end else begin
                        emit_c = 1'b1;
                        if (in_idx == LAST_IDX) begin
                            state_next = S_FLUSH;
                        end
                    end
                end
            end
            S_FLUSH: begin
                // push dummy pixels so the delay lines keep advancing
                shift_pix_c = '0;
                emit_c      = 1'b1;
                if (cen_x == X_LAST && cen_y == Y_LAST) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
        shift_c = store_c | (state == S_FLUSH);
    end

    assign top_rd_c = line_top[wr_ptr];
    assign mid_rd_c = line_mid[wr_ptr];

    // 3x3 view as it will stand after this cycle's shift; column 2 is the
    // incoming column, so the window is ready on the same edge
    always_comb begin
        win_c[0][0] = col_b_top;
        win_c[0][1] = col_a_top;
        win_c[0][2] = top_rd_c;
        win_c[1][0] = col_b_mid;
        win_c[1][1] = col_a_mid;
        win_c[1][2] = mid_rd_c;
        win_c[2][0] = col_b_bot;
        win_c[2][1] = col_a_bot;
        win_c[2][2] = shift_pix_c;
    end

    // edge replication: an out-of-frame neighbour falls back to the centre row/column
    always_comb begin
        r_up_c = (cen_y == '0)    ? 2'd1 : 2'd0;
        r_dn_c = (cen_y == Y_LAST) ? 2'd1 : 2'd2;
        c_lf_c = (cen_x == '0)    ? 2'd1 : 2'd0;
        c_rt_c = (cen_x == X_LAST) ? 2'd1 : 2'd2;
        pack_c = {win_c[1][1],
                  win_c[1][c_lf_c],
                  win_c[1][c_rt_c],
                  win_c[r_up_c][1],
                  win_c[r_dn_c][1],
                  win_c[r_up_c][c_lf_c],
                  win_c[r_up_c][c_rt_c],
                  win_c[r_dn_c][c_lf_c],
                  win_c[r_dn_c][c_rt_c]};
    end

    // datapath: line buffers, window columns, counters and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready     <= 1'b0;
            window_valid <= 1'b0;
            color_data   <= '0;
            x_out        <= '0;
            y_out        <= '0;
            in_idx       <= '0;
            cen_x        <= '0;
            cen_y        <= '0;
            wr_ptr       <= '0;
            col_a_top    <= '0;
            col_a_mid    <= '0;
            col_a_bot    <= '0;
            col_b_top    <= '0;
            col_b_mid    <= '0;
            col_b_bot    <= '0;
            for (int unsigned i = 0; i < IMG_WIDTH; i++) begin
                line_mid[PTR_W'(i)] <= '0;
                line_top[PTR_W'(i)] <= '0;
            end
        end else begin
            in_ready     <= (state_next != S_FLUSH);
            window_valid <= emit_c;

            if (shift_c) begin
                line_mid[wr_ptr] <= shift_pix_c;
                line_top[wr_ptr] <= mid_rd_c;
                col_b_top        <= col_a_top;
                col_b_mid        <= col_a_mid;
                col_b_bot        <= col_a_bot;
                col_a_top        <= top_rd_c;
                col_a_mid        <= mid_rd_c;
                col_a_bot        <= shift_pix_c;
                wr_ptr           <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
            end

            if (restart_c) begin
                in_idx <= IW'(1);
            end else if (store_c) begin
                in_idx <= in_idx + IW'(1);
            end

            if (restart_c) begin
                cen_x <= '0;
                cen_y <= '0;
            end else if (emit_c) begin
                color_data <= pack_c;
                x_out      <= cen_x;
                y_out      <= cen_y;
                if (cen_x == X_LAST) begin
                    cen_x <= '0;
                    cen_y <= cen_y + CW'(1);
                end else begin
                    cen_x <= cen_x + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_window_3x3_builder.sv
// Self-checking bench for window_3x3_builder on a 4x3 image. A frame-level
// reference model stores accepted pixels and derives each expected window
// from clamped neighbour coordinates.
module tb_window_3x3_builder;

    localparam int W   = 4;
    localparam int H   = 3;
    localparam int PW  = 12;
    localparam int N   = W * H;
    localparam int CDW = 9 * PW;

    logic            clk = 1'b0;
    logic            reset;
    logic            frame_start;
    logic [PW-1:0]   pixel_in;
    logic            pixel_valid;
    logic            in_ready;
    logic [CDW-1:0]  color_data;
    logic            window_valid;
    logic [15:0]     x_out;
    logic [15:0]     y_out;

    always #5 clk = ~clk;

    window_3x3_builder #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .PIX_W     (PW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .pixel_in    (pixel_in),
        .pixel_valid (pixel_valid),
        .in_ready    (in_ready),
        .color_data  (color_data),
        .window_valid(window_valid),
        .x_out       (x_out),
        .y_out       (y_out)
    );

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    logic [PW-1:0] frame_pix [N];
    logic [PW-1:0] src [N];
    bit            m_active = 1'b0;
    bit            m_flush  = 1'b0;
    bit            m_ready  = 1'b0;
    int            m_acc    = 0;
    int            m_em     = 0;
    int            obs_strobes = 0;
    logic [CDW-1:0] last_cd = '0;

    task automatic check_eq(input string tag, input logic [CDW-1:0] got, input logic [CDW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic logic [PW-1:0] pix_at(input int x, input int y);
        return frame_pix[clampi(y, H - 1) * W + clampi(x, W - 1)];
    endfunction

    function automatic logic [CDW-1:0] exp_win(input int c);
        int x;
        int y;
        x = c % W;
        y = c / W;
        return {pix_at(x, y), pix_at(x - 1, y), pix_at(x + 1, y),
                pix_at(x, y - 1), pix_at(x, y + 1),
                pix_at(x - 1, y - 1), pix_at(x + 1, y - 1),
                pix_at(x - 1, y + 1), pix_at(x + 1, y + 1)};
    endfunction

    // one clock: drive inputs, advance the model, check outputs after the edge
    task automatic cyc(input bit rst, input bit fs, input bit pv, input logic [PW-1:0] pix);
        bit             strobe;
        int             e_c;
        logic [CDW-1:0] e_cd;
        strobe = 1'b0;
        e_c    = 0;
        e_cd   = '0;
        reset       = rst;
        frame_start = fs;
        pixel_valid = pv;
        pixel_in    = pix;
        if (rst) begin
            m_active = 1'b0;
            m_flush  = 1'b0;
            m_acc    = 0;
            m_em     = 0;
        end else if (m_flush) begin
            strobe = 1'b1;
            e_c    = m_em;
            m_em++;
            if (m_em == N) begin
                m_flush  = 1'b0;
                m_active = 1'b0;
            end
        end else if (pv && m_ready) begin
            if (fs) begin
                m_active     = 1'b1;
                frame_pix[0] = pix;
                m_acc        = 1;
                m_em         = 0;
            end else if (m_active) begin
                frame_pix[m_acc] = pix;
                if (m_acc >= W + 1) begin
                    strobe = 1'b1;
                    e_c    = m_acc - W - 1;
                    m_em++;
                end
                if (m_acc == N - 1) m_flush = 1'b1;
                m_acc++;
            end
        end
        if (strobe) e_cd = exp_win(e_c);
        @(posedge clk);
        #1;
        m_ready = !rst && !m_flush;
        check_eq("in_ready", CDW'(in_ready), CDW'(m_ready));
        check_eq("window_valid", CDW'(window_valid), CDW'(strobe));
        if (rst) begin
            check_eq("rst_color_data", color_data, '0);
            check_eq("rst_x_out", CDW'(x_out), '0);
            check_eq("rst_y_out", CDW'(y_out), '0);
        end else if (strobe) begin
            check_eq("color_data", color_data, e_cd);
            check_eq("x_out", CDW'(x_out), CDW'(e_c % W));
            check_eq("y_out", CDW'(y_out), CDW'(e_c / W));
            last_cd = color_data;
        end
        if (window_valid) obs_strobes++;
    endtask

    // vmode 0: back-to-back, 1: valid toggles every cycle, 2: random stalls
    task automatic send_pix(input int i, input int vmode);
        int stalls;
        stalls = (vmode == 0) ? 0 : (vmode == 1) ? ((i == 0) ? 0 : 1) : int'($urandom_range(0, 2));
        for (int s = 0; s < stalls; s++) cyc(1'b0, 1'b0, 1'b0, PW'($urandom));
        cyc(1'b0, i == 0, 1'b1, src[i]);
    endtask

    // flush tail: stray valid pixels without frame_start must be ignored
    task automatic tail(input int cycles);
        for (int k = 0; k < cycles; k++) cyc(1'b0, 1'b0, 1'($urandom), PW'($urandom));
    endtask

    task automatic fill_random();
        for (int i = 0; i < N; i++) src[i] = PW'($urandom);
    endtask

    initial begin
        logic [CDW-1:0] tp_first;
        logic [CDW-1:0] tp_mid;
        logic [CDW-1:0] tp_last;
        logic [CDW-1:0] tp_restart;
        tp_first   = {12'd0, 12'd0, 12'd1, 12'd0, 12'd4, 12'd0, 12'd1, 12'd4, 12'd5};
        tp_mid     = {12'd5, 12'd4, 12'd6, 12'd1, 12'd9, 12'd0, 12'd2, 12'd8, 12'd10};
        tp_last    = {12'd11, 12'd10, 12'd11, 12'd7, 12'd11, 12'd6, 12'd7, 12'd10, 12'd11};
        tp_restart = {12'd100, 12'd100, 12'd101, 12'd100, 12'd104, 12'd100, 12'd101, 12'd104, 12'd105};

        // reset, then one idle cycle so in_ready comes up
        cyc(1'b1, 1'b0, 1'b0, '0);
        cyc(1'b1, 1'b0, 1'b1, '0);
        cyc(1'b0, 1'b0, 1'b0, '0);

        // directed frame: pixels 0..11 back-to-back
        for (int i = 0; i < N; i++) src[i] = PW'(i);
        obs_strobes = 0;
        for (int i = 0; i < N; i++) begin
            send_pix(i, 0);
            if (i == 5)  check_eq("tp_first_window", last_cd, tp_first);
            if (i == 10) check_eq("tp_centre_1_1", last_cd, tp_mid);
        end
        for (int k = 0; k < W + 1; k++) cyc(1'b0, 1'b0, 1'b0, '0);
        check_eq("tp_last_window", last_cd, tp_last);
        check_eq("tp_strobe_count", CDW'(obs_strobes), CDW'(N));
        cyc(1'b0, 1'b0, 1'b0, '0);

        // same pixels with pixel_valid toggling every cycle
        obs_strobes = 0;
        for (int i = 0; i < N; i++) send_pix(i, 1);
        tail(W + 3);
        check_eq("toggle_strobe_count", CDW'(obs_strobes), CDW'(N));

        // frame_start re-asserted at index 7 with a new frame 100..111
        for (int i = 0; i < 7; i++) send_pix(i, 0);
        for (int i = 0; i < N; i++) src[i] = PW'(100 + i);
        obs_strobes = 0;
        for (int i = 0; i < N; i++) begin
            send_pix(i, 0);
            if (i == 5) check_eq("restart_first_window", last_cd, tp_restart);
        end
        tail(W + 3);
        check_eq("restart_strobe_count", CDW'(obs_strobes), CDW'(N));

        // reset during RUN, stray pixels, then a full random frame
        fill_random();
        for (int i = 0; i < 8; i++) send_pix(i, 0);
        cyc(1'b1, 1'b0, 1'b1, PW'($urandom));
        obs_strobes = 0;
        for (int k = 0; k < 6; k++) cyc(1'b0, 1'b0, 1'b1, PW'($urandom));
        check_eq("dropped_no_strobe", CDW'(obs_strobes), '0);
        fill_random();
        for (int i = 0; i < N; i++) send_pix(i, 2);
        tail(W + 3);
        check_eq("post_reset_strobe_count", CDW'(obs_strobes), CDW'(N));

        // random frames with random stalls
        for (int f = 0; f < 4; f++) begin
            fill_random();
            obs_strobes = 0;
            for (int i = 0; i < N; i++) send_pix(i, 2);
            tail(W + 3);
            check_eq("random_strobe_count", CDW'(obs_strobes), CDW'(N));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
